// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sharing of one single-port RAM between fetch (port 0) and load/store (port 1).
// Faulted accesses are granted but never reach the RAM; responses arrive one cycle after the grant.
module ram_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int SIZE = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p1_req,
    input  logic                  p0_we,
    input  logic                  p1_we,
    input  logic [31:0]           p0_addr,
    input  logic [31:0]           p1_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p0_gnt,
    output logic                  p1_gnt,
    output logic                  p0_rvalid,
    output logic                  p1_rvalid,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  p0_err,
    output logic                  p1_err,
    output logic [31:0]           ram_index,
    output logic [DATA_WIDTH-1:0] ram_entry,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_entry_out
);
    logic prio, rsp_pend, rsp_port, rsp_rd, rsp_err;
    logic gnt, sel, we, fault, ok, rv, good_rd;
    logic [31:0] addr, idx;
    logic [DATA_WIDTH-1:0] wdata;

    always_comb begin
        gnt = ~rst & (p0_req | p1_req);
        sel = (p0_req & p1_req) ? prio : p1_req;
        p0_gnt = gnt & ~sel;
        p1_gnt = gnt & sel;
        we = sel ? p1_we : p0_we;
        addr = sel ? p1_addr : p0_addr;
        wdata = sel ? p1_wdata : p0_wdata;
        idx = {2'b00, addr[31:2]};
        fault = (addr[1:0] != 2'b00) || (idx >= 32'(SIZE));
        ok = gnt & ~fault;
        ram_index = ok ? idx : '0;
        ram_entry = ok ? wdata : '0;
        ram_wr_en = ok & we;
        // a pending response is dropped if reset arrives in its cycle
        rv = rsp_pend & ~rst;
        good_rd = rsp_rd & ~rsp_err;
        p0_rvalid = rv & ~rsp_port & rsp_rd;
        p1_rvalid = rv & rsp_port & rsp_rd;
        p0_err = rv & ~rsp_port & rsp_err;
        p1_err = rv & rsp_port & rsp_err;
        p0_rdata = (rv & ~rsp_port & good_rd) ? ram_entry_out : '0;
        p1_rdata = (rv & rsp_port & good_rd) ? ram_entry_out : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b1;
            rsp_pend <= 1'b0;
            rsp_port <= 1'b0;
            rsp_rd <= 1'b0;
            rsp_err <= 1'b0;
        end else begin
            rsp_pend <= gnt;
            if (gnt) begin
                prio <= ~sel;
                rsp_port <= sel;
                rsp_rd <= ~we;
                rsp_err <= fault;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors against ram_arbiter with a behavioural single-port RAM attached.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic p0_req, p1_req, p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata, ram_index, ram_entry, ram_entry_out;
    logic ram_wr_en;
    logic [31:0] mem [256];
    logic written [256];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_WIDTH(32), .SIZE(256)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata), .p0_err(p0_err), .p1_err(p1_err),
        .ram_index(ram_index), .ram_entry(ram_entry), .ram_wr_en(ram_wr_en),
        .ram_entry_out(ram_entry_out)
    );

    // unwritten words read back as 0xA000_0000 | index
    always @(posedge clk) begin
        if (ram_wr_en) begin
            mem[ram_index[7:0]] <= ram_entry;
            written[ram_index[7:0]] <= 1'b1;
        end
        ram_entry_out <= (written[ram_index[7:0]] === 1'b1) ? mem[ram_index[7:0]] : (32'hA000_0000 | {24'd0, ram_index[7:0]});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        @(negedge clk);
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next;
        drive(1, 0, 32'h0, 0, 1, 1, 32'h4, 32'h55);
        check("rst_p0_gnt", 32'(p0_gnt), 0);
        check("rst_p1_gnt", 32'(p1_gnt), 0);
        check("rst_wr_en", 32'(ram_wr_en), 0);
        check("rst_index", ram_index, 0);
        check("rst_entry", ram_entry, 0);
        check("rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 0);
        check("rst_err", {30'd0, p0_err, p1_err}, 0);
        check("rst_rdata", p0_rdata | p1_rdata, 0);
        next;
        rst = 1'b0;
        // alternating conflict: 1,0,1,0; responses one cycle later on the right port
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
            check($sformatf("rr%0d_p1_gnt", i), 32'(p1_gnt), (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_p0_gnt", i), 32'(p0_gnt), (i % 2 == 0) ? 0 : 1);
            check($sformatf("rr%0d_index", i), ram_index, (i % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_p1_rvalid", i), 32'(p1_rvalid), (i % 2 == 1) ? 1 : 0);
            check($sformatf("rr%0d_p0_rvalid", i), 32'(p0_rvalid), (i >= 2 && i % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_p1_rdata", i), p1_rdata, (i % 2 == 1) ? 32'hA000_0001 : 0);
            check($sformatf("rr%0d_p0_rdata", i), p0_rdata, (i >= 2 && i % 2 == 0) ? 32'hA000_0000 : 0);
            next;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("rr_tail_p0_rvalid", 32'(p0_rvalid), 1);
        check("rr_tail_p0_rdata", p0_rdata, 32'hA000_0000);
        check("rr_tail_p1_rvalid", 32'(p1_rvalid), 0);
        next;
        // write then read-after-write of the same word
        drive(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
        check("wr_p1_gnt", 32'(p1_gnt), 1);
        check("wr_wr_en", 32'(ram_wr_en), 1);
        check("wr_index", ram_index, 4);
        check("wr_entry", ram_entry, 32'hDEAD_BEEF);
        next;
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        check("raw_p0_gnt", 32'(p0_gnt), 1);
        check("raw_wr_en", 32'(ram_wr_en), 0);
        check("wr_no_rvalid", 32'(p1_rvalid), 0);
        check("wr_no_err", 32'(p1_err), 0);
        next;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("raw_rvalid", 32'(p0_rvalid), 1);
        check("raw_rdata", p0_rdata, 32'hDEAD_BEEF);
        check("raw_idle_wr_en", 32'(ram_wr_en), 0);
        next;
        // misaligned read on port 1
        drive(0, 0, 0, 0, 1, 0, 32'h2, 0);
        check("mis_p1_gnt", 32'(p1_gnt), 1);
        check("mis_wr_en", 32'(ram_wr_en), 0);
        next;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("mis_rvalid", 32'(p1_rvalid), 1);
        check("mis_err", 32'(p1_err), 1);
        check("mis_rdata", p1_rdata, 0);
        check("mis_p0_quiet", {30'd0, p0_rvalid, p0_err}, 0);
        next;
        // range boundaries on port 0
        drive(1, 1, 32'h3FC, 32'h1234_5678, 0, 0, 0, 0);
        check("top_gnt", 32'(p0_gnt), 1);
        check("top_wr_en", 32'(ram_wr_en), 1);
        check("top_index", ram_index, 255);
        next;
        drive(1, 1, 32'h400, 32'h1111_1111, 0, 0, 0, 0);
        check("oor_gnt", 32'(p0_gnt), 1);
        check("oor_wr_en", 32'(ram_wr_en), 0);
        check("top_resp_err", 32'(p0_err), 0);
        check("top_resp_rvalid", 32'(p0_rvalid), 0);
        next;
        drive(1, 1, 32'hFFFF_FFFC, 32'h2222_2222, 0, 0, 0, 0);
        check("max_wr_en", 32'(ram_wr_en), 0);
        check("oor_err", 32'(p0_err), 1);
        check("oor_rvalid", 32'(p0_rvalid), 0);
        next;
        drive(1, 0, 32'h3FC, 0, 0, 0, 0, 0);
        check("max_err", 32'(p0_err), 1);
        check("top_rd_index", ram_index, 255);
        next;
        drive(1, 1, 32'h11, 32'h3333_3333, 0, 0, 0, 0);
        check("top_rd_rvalid", 32'(p0_rvalid), 1);
        check("top_rd_rdata", p0_rdata, 32'h1234_5678);
        check("top_rd_err", 32'(p0_err), 0);
        check("miswr_wr_en", 32'(ram_wr_en), 0);
        next;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("miswr_err", 32'(p0_err), 1);
        check("miswr_rvalid", 32'(p0_rvalid), 0);
        next;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("err_pulse_end", 32'(p0_err), 0);
        next;
        // solo requester gets back-to-back grants
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 32'h0, 0, 0, 0, 0, 0);
            check($sformatf("solo%0d_p0_gnt", i), 32'(p0_gnt), 1);
            check($sformatf("solo%0d_p1_gnt", i), 32'(p1_gnt), 0);
            next;
        end
        drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        check("solo_then_p1", 32'(p1_gnt), 1);
        next;
        drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        check("solo_then_p0", 32'(p0_gnt), 1);
        next;
        // reset swallows an in-flight read and restores priority
        drive(0, 0, 0, 0, 1, 0, 32'h4, 0);
        check("mid_p1_gnt", 32'(p1_gnt), 1);
        next;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("mid_rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 0);
        check("mid_rst_err", {30'd0, p0_err, p1_err}, 0);
        next;
        rst = 1'b0;
        drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        check("post_rst_rvalid", {30'd0, p0_rvalid, p1_rvalid}, 0);
        check("post_rst_err", {30'd0, p0_err, p1_err}, 0);
        check("post_rst_p1_gnt", 32'(p1_gnt), 1);
        check("post_rst_p0_gnt", 32'(p0_gnt), 0);
        next;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("post_rst_p1_rvalid", 32'(p1_rvalid), 1);
        next;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
